bitcoin_hash_host: RTL and testbench

Memory-side responder and host controller for the bitcoin hasher's memory-master interface. Holds the message/result word memory, answers the hasher's reads with one-cycle latency and absorbs its writes. Issues the `start` pulse, waits for `done`, then scans the 16 written hash words (one per nonce) and reports the smallest one with its nonce index. Sits between the system/testbench loader and the hasher core.

---
 rtl/bitcoin_hash_host.sv | 186 ++++++++++++++++++
 tb/tb_bitcoin_hash_host.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitcoin_hash_host.sv
// Memory responder and host sequencer for the bitcoin hasher: serves its reads and writes, then scans the result window for the minimum hash.
// Optional watchdog in RUN is enabled with `define BITCOIN_HASH_HOST_WATCHDOG_EN.
module bitcoin_hash_host #(
  parameter int          MEM_DEPTH      = 1024,
  parameter logic [15:0] MSG_ADDR       = 16'h0000,
  parameter logic [15:0] OUT_ADDR       = 16'h0200,
  parameter int          OUT_WORDS      = 16,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        run,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        best_valid,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        err_oob,
  output logic        err_count,
  output logic        err_timeout
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_SCAN, S_REPORT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  wr_cnt_q, wr_cnt_d;
  logic [4:0]  scan_idx_q, scan_idx_d;
  logic [31:0] scan_rd_q, scan_rd_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] best_hash_q, best_hash_d;
  logic [3:0]  best_nonce_q, best_nonce_d;
  logic        err_oob_q, err_oob_d;
  logic        err_count_q, err_count_d;
  logic        timeout_hit;

  logic [31:0] mem [MEM_DEPTH];

  logic        host_in, load_in, win_hit, host_wr, load_wr, scan_in;
  logic [15:0] scan_addr;
  logic [31:0] host_word, scan_word;

  assign host_in   = ({1'b0, mem_addr} < 17'(MEM_DEPTH));
  assign load_in   = ({1'b0, load_addr} < 17'(MEM_DEPTH));
  assign win_hit   = (mem_addr >= OUT_ADDR) && (mem_addr < OUT_ADDR + 16'(OUT_WORDS));
  assign host_wr   = (state_q == S_RUN) && mem_we && host_in;
  assign load_wr   = (state_q == S_IDLE) && load_valid && load_in;
  assign scan_addr = OUT_ADDR + {11'b0, scan_idx_q};
  assign scan_in   = ({1'b0, scan_addr} < 17'(MEM_DEPTH));
  assign host_word = host_in ? mem[mem_addr[AW-1:0]] : 32'h0;
  assign scan_word = scan_in ? mem[scan_addr[AW-1:0]] : 32'h0;

  // Storage is deliberately not reset so a preload survives a reset.
  always_ff @(posedge clk) begin
    if (host_wr)      mem[mem_addr[AW-1:0]]  <= mem_write_data;
    else if (load_wr) mem[load_addr[AW-1:0]] <= load_data;
  end

`ifdef BITCOIN_HASH_HOST_WATCHDOG_EN
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        err_timeout_q, err_timeout_d;

  assign timeout_hit = (state_q == S_RUN) && (run_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_timeout_q;

  always_comb begin
    run_cnt_d     = run_cnt_q;
    err_timeout_d = err_timeout_q;
    if (state_q == S_START) begin
      run_cnt_d     = 32'h0;
      err_timeout_d = 1'b0;
    end else if (state_q == S_RUN) begin
      run_cnt_d = run_cnt_q + 32'h1;
      if (timeout_hit && !done) err_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt_q     <= 32'h0;
      err_timeout_q <= 1'b0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= 5'd0;
      scan_idx_q   <= 5'd0;
      scan_rd_q    <= 32'h0;
      rd_data_q    <= 32'h0;
      best_hash_q  <= 32'h0;
      best_nonce_q <= 4'd0;
      err_oob_q    <= 1'b0;
      err_count_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      scan_idx_q   <= scan_idx_d;
      scan_rd_q    <= scan_rd_d;
      rd_data_q    <= rd_data_d;
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
      err_oob_q    <= err_oob_d;
      err_count_q  <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN:    if (done || timeout_hit) state_d = S_SCAN;
      S_SCAN:   if (scan_idx_q == 5'(OUT_WORDS)) state_d = S_REPORT;
      S_REPORT: if (run) state_d = S_START;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    scan_idx_d   = scan_idx_q;
    scan_rd_d    = scan_rd_q;
    rd_data_d    = rd_data_q;
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;
    err_oob_d    = err_oob_q;
    err_count_d  = err_count_q;
    case (state_q)
      S_START: begin
        wr_cnt_d    = 5'd0;
        err_count_d = 1'b0;
      end
      S_RUN: begin
        rd_data_d  = host_word;
        scan_idx_d = 5'd0;
        if (!host_in) err_oob_d = 1'b1;
        if (mem_we && win_hit && wr_cnt_q != 5'd31) wr_cnt_d = wr_cnt_q + 5'd1;
        if (done || timeout_hit) err_count_d = (wr_cnt_d != 5'(OUT_WORDS));
      end
      S_SCAN: begin
        // Reads are issued one cycle ahead; scan_rd_q holds word (scan_idx_q - 1).
        scan_idx_d = scan_idx_q + 5'd1;
        scan_rd_d  = scan_word;
        if (scan_idx_q != 5'd0 && (scan_idx_q == 5'd1 || scan_rd_q < best_hash_q)) begin
          best_hash_d  = scan_rd_q;
          best_nonce_d = 4'(scan_idx_q - 5'd1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    start         = (state_q == S_START);
    busy          = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_SCAN);
    best_valid    = (state_q == S_REPORT);
    message_addr  = MSG_ADDR;
    output_addr   = OUT_ADDR;
    mem_read_data = rd_data_q;
    best_nonce    = best_nonce_q;
    best_hash     = best_hash_q;
    err_oob       = err_oob_q;
    err_count     = err_count_q;
  end

endmodule

// File: tb/tb_bitcoin_hash_host.sv
// Directed bench for bitcoin_hash_host: result-scan vectors plus read, out-of-range, reset and watchdog sequences.
module tb_bitcoin_hash_host;

  localparam logic [15:0] OUT_ADDR = 16'h0200;

  logic        clk = 1'b0;
  logic        reset, load_valid, run, done, mem_we;
  logic [15:0] load_addr, mem_addr;
  logic [31:0] load_data, mem_write_data;
  logic        start, busy, best_valid, err_oob, err_count, err_timeout;
  logic [15:0] message_addr, output_addr;
  logic [31:0] mem_read_data, best_hash;
  logic [3:0]  best_nonce;

  int total = 0;
  int bad   = 0;

  bitcoin_hash_host #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_addr(load_addr),
    .load_data(load_data), .run(run), .start(start), .message_addr(message_addr),
    .output_addr(output_addr), .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy),
    .best_valid(best_valid), .best_nonce(best_nonce), .best_hash(best_hash),
    .err_oob(err_oob), .err_count(err_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][31:0] words;
    int                nwr;
    logic [3:0]        exp_nonce;
    logic [31:0]       exp_hash;
    logic              exp_errc;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE_0000 | 32'(i));
  endfunction

  task automatic finish_scan(input string tag);
    for (int i = 0; i < 16; i++) step();
    chk({tag, "_bv_early"}, 32'(best_valid), 32'd0);
    step();
    chk({tag, "_bv"}, 32'(best_valid), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic do_vec(input int v);
    int idx;
    run = 1'b1;
    step();
    chk("start_on", 32'(start), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
    run = 1'b0;
    step();
    chk("start_off", 32'(start), 32'd0);
    for (int k = 0; k < vecs[v].nwr; k++) begin
      idx            = (k < 16) ? k : 15;
      mem_we         = 1'b1;
      mem_addr       = OUT_ADDR + 16'(idx);
      mem_write_data = vecs[v].words[idx];
      step();
    end
    mem_we   = 1'b0;
    mem_addr = 16'h0;
    done     = 1'b1;
    run      = 1'b1;  // same-cycle run with done must be ignored
    step();
    run = 1'b0;
    finish_scan($sformatf("vec%0d", v));
    chk($sformatf("vec%0d_nonce", v), 32'(best_nonce), 32'(vecs[v].exp_nonce));
    chk($sformatf("vec%0d_hash", v), best_hash, vecs[v].exp_hash);
    chk($sformatf("vec%0d_errc", v), 32'(err_count), 32'(vecs[v].exp_errc));
    done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    run = 1'b0; done = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_write_data = '0;

    // descending words: last index is smallest
    for (int i = 0; i < 16; i++) vecs[0].words[i] = 32'hF000_0000 - 32'(i);
    vecs[0].nwr = 16; vecs[0].exp_nonce = 4'd15; vecs[0].exp_hash = 32'hEFFF_FFF1; vecs[0].exp_errc = 1'b0;
    // tie between index 3 and 9
    for (int i = 0; i < 16; i++) vecs[1].words[i] = (i == 3 || i == 9) ? 32'd5 : 32'hFFFF_FFFF;
    vecs[1].nwr = 16; vecs[1].exp_nonce = 4'd3; vecs[1].exp_hash = 32'd5; vecs[1].exp_errc = 1'b0;
    // 15 writes; word 15 keeps FFFF_FFFF from the previous run
    for (int i = 0; i < 16; i++) vecs[2].words[i] = 32'd1000 - 32'(i);
    vecs[2].nwr = 15; vecs[2].exp_nonce = 4'd14; vecs[2].exp_hash = 32'd986; vecs[2].exp_errc = 1'b1;
    for (int i = 0; i < 16; i++) vecs[3].words[i] = 32'd7;
    vecs[3].nwr = 16; vecs[3].exp_nonce = 4'd0; vecs[3].exp_hash = 32'd7; vecs[3].exp_errc = 1'b0;
    for (int i = 0; i < 16; i++) vecs[4].words[i] = 32'h10 + 32'(i);
    vecs[4].nwr = 16; vecs[4].exp_nonce = 4'd0; vecs[4].exp_hash = 32'h10; vecs[4].exp_errc = 1'b0;
    for (int i = 0; i < 16; i++) vecs[5].words[i] = (i == 15) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
    vecs[5].nwr = 16; vecs[5].exp_nonce = 4'd15; vecs[5].exp_hash = 32'hFFFF_FFFE; vecs[5].exp_errc = 1'b0;
    // 17 writes (index 15 twice) is a count error
    for (int i = 0; i < 16; i++) vecs[6].words[i] = 32'h8000_0000 + 32'(i);
    vecs[6].nwr = 17; vecs[6].exp_nonce = 4'd0; vecs[6].exp_hash = 32'h8000_0000; vecs[6].exp_errc = 1'b1;

    step(); step();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_bv", 32'(best_valid), 32'd0);
    chk("rst_hash", best_hash, 32'd0);
    chk("rst_nonce", 32'(best_nonce), 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    chk("rst_errs", {29'd0, err_oob, err_count, err_timeout}, 32'd0);
    chk("msg_addr", 32'(message_addr), 32'h0000);
    chk("out_addr", 32'(output_addr), 32'h0200);

    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1; load_addr = 16'(i); load_data = pre(i);
      step();
    end
    load_valid = 1'b0;

    for (int v = 0; v < 7; v++) do_vec(v);

    // watchdog / no-done sequence
    run = 1'b1;
    step();
    chk("wd_start", 32'(start), 32'd1);
    run = 1'b0;
`ifdef BITCOIN_HASH_HOST_WATCHDOG_EN
    for (int i = 0; i < 67; i++) step();
    chk("wd_bv_early", 32'(best_valid), 32'd0);
    step();
    chk("wd_bv", 32'(best_valid), 32'd1);
    chk("wd_timeout", 32'(err_timeout), 32'd1);
    chk("wd_errc", 32'(err_count), 32'd1);
`else
    for (int i = 0; i < 200; i++) step();
    chk("wd_busy_hold", 32'(busy), 32'd1);
    chk("wd_timeout_off", 32'(err_timeout), 32'd0);
    done = 1'b1;
    step();
    finish_scan("wd_done");
    done = 1'b0;
`endif

    // read latency, read-before-write, out-of-range
    run = 1'b1; step(); run = 1'b0; step();
    chk("rw_timeout_clr", 32'(err_timeout), 32'd0);
    for (int i = 0; i < 20; i++) begin
      mem_addr = 16'(i);
      step();
      chk($sformatf("rd_pre%0d", i), mem_read_data, pre(i));
    end
    mem_addr = 16'd4; step();
    mem_addr = 16'd5;
    chk("rd_lat_before", mem_read_data, pre(4));
    step();
    chk("rd_lat_after", mem_read_data, 32'hDEADBEEF);
    mem_addr = 16'd6; mem_we = 1'b1; mem_write_data = 32'h1234_5678;
    step();
    chk("rd_old_on_wr", mem_read_data, pre(6));
    mem_we = 1'b0;
    step();
    chk("rd_new", mem_read_data, 32'h1234_5678);
    chk("oob_clear", 32'(err_oob), 32'd0);
    mem_addr = 16'h0400;
    step();
    chk("oob_rd", mem_read_data, 32'h0);
    chk("oob_flag", 32'(err_oob), 32'd1);
    mem_we = 1'b1; mem_write_data = 32'hBAD0_BAD0;
    step();
    mem_we = 1'b0; mem_addr = 16'h0;
    step();
    chk("oob_wr_drop", mem_read_data, pre(0));
    done = 1'b1;
    step();
    finish_scan("rw");
    chk("rw_errc", 32'(err_count), 32'd1);
    chk("oob_sticky", 32'(err_oob), 32'd1);
    done = 1'b0;
    // REPORT: hasher writes and preloads ignored, read data holds
    mem_we = 1'b1; mem_addr = 16'd5; mem_write_data = 32'h0;
    load_valid = 1'b1; load_addr = 16'd8; load_data = 32'h0;
    step();
    chk("rep_rd_hold", mem_read_data, pre(0));
    mem_we = 1'b0; load_valid = 1'b0; mem_addr = 16'h0;

    // reset in RUN cycle 100
    run = 1'b1; step(); run = 1'b0;
    for (int i = 0; i < 100; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_start", 32'(start), 32'd0);
    chk("mrst_bv", 32'(best_valid), 32'd0);
    chk("mrst_oob", 32'(err_oob), 32'd0);
    chk("mrst_rdata", mem_read_data, 32'd0);
    chk("mrst_hash", best_hash, 32'd0);
    run = 1'b1; step(); run = 1'b0; step();
    mem_addr = 16'd5; step();
    chk("post_rst_rd5", mem_read_data, 32'hDEADBEEF);
    mem_addr = 16'd8; step();
    chk("post_rst_rd8", mem_read_data, pre(8));
    mem_addr = 16'd6; step();
    chk("post_rst_rd6", mem_read_data, 32'h1234_5678);
    mem_addr = 16'h0; done = 1'b1;
    step();
    finish_scan("post_rst");
    done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
